vdc_video_out: RTL

- Pixel output stage of the VDC, directly downstream of vdc_signals.
- Consumes the column/pixel timing strobes, visibility flags, cursor/blink state and syncs from vdc_signals, plus the character bitmap and attribute bytes from the fetch stage.
- Produces the final 4-bit RGBI pixel stream with hsync/vsync delayed to stay pixel-aligned.
- Implements text and bitmap modes, attributes, cursor, underline, blink, reverse video and semigraphics.

---
 rtl/vdc_video_out.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/vdc_video_out.sv
// Pixel output stage of the VDC: a two-stage pipeline that turns column bytes,
// attributes, cursor and blink state into an RGBI stream with pixel-aligned syncs.
module vdc_video_out (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       newCol,
  input  logic [3:0] pixel,
  input  logic [4:0] line,
  input  logic       hVisible,
  input  logic       vVisible,
  input  logic       hdispen,
  input  logic       cursorV,
  input  logic [1:0] blink,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [7:0] bitmap,
  input  logic [7:0] attr,
  input  logic       curCol,
  input  logic [3:0] reg_cth,
  input  logic [3:0] reg_cdh,
  input  logic [4:0] reg_ul,
  input  logic [1:0] reg_cm,
  input  logic       reg_rvs,
  input  logic       reg_cbrate,
  input  logic       reg_text,
  input  logic       reg_atr,
  input  logic       reg_semi,
  input  logic [3:0] reg_fg,
  input  logic [3:0] reg_bg,
  output logic [3:0] rgbi,
  output logic       de,
  output logic       hsync_o,
  output logic       vsync_o
);

  logic [3:0] pix_q;
  logic [4:0] line_q;
  logic       vis_q;
  logic       curv_q;
  logic       hs_q;
  logic       vs_q;
  logic [7:0] bitmap_q;
  logic [7:0] attr_q;
  logic       curcol_q;

  // Stage A: timing strobes every tick, column data only on the first pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_q    <= '0;
      line_q   <= '0;
      vis_q    <= 1'b0;
      curv_q   <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      bitmap_q <= '0;
      attr_q   <= '0;
      curcol_q <= 1'b0;
    end else if (enable) begin
      pix_q  <= pixel;
      line_q <= line;
      vis_q  <= hVisible & vVisible & hdispen;
      curv_q <= cursorV;
      hs_q   <= hsync;
      vs_q   <= vsync;
      if (newCol) begin
        bitmap_q <= bitmap;
        attr_q   <= attr;
        curcol_q <= curCol;
      end
    end
  end

  logic       pix_bit;
  logic       mode_on;
  logic [3:0] fg_c;
  logic [3:0] bg_c;
  logic [3:0] rgbi_d;
  logic       de_d;

  always_comb begin
    pix_bit = 1'b0;
    mode_on = 1'b0;
    fg_c    = reg_fg;
    bg_c    = reg_bg;
    rgbi_d  = '0;
    de_d    = 1'b0;

    // Pixels beyond the character total never show glyph data.
    if (pix_q > reg_cth)
      pix_bit = 1'b0;
    else if ((pix_q <= reg_cdh) && (pix_q < 4'd8))
      pix_bit = bitmap_q[3'd7 - pix_q[2:0]];
    else
      pix_bit = reg_semi & bitmap_q[0];

    if (reg_atr) begin
      if (reg_text) begin
        fg_c = attr_q[7:4];
        bg_c = attr_q[3:0];
      end else begin
        fg_c = attr_q[3:0];
        if (attr_q[4] && blink[reg_cbrate]) pix_bit = 1'b0;
        if (attr_q[5] && (line_q == reg_ul)) pix_bit = 1'b1;
        if (attr_q[6]) pix_bit = ~pix_bit;
      end
    end

    case (reg_cm)
      2'b00:   mode_on = 1'b1;
      2'b01:   mode_on = 1'b0;
      2'b10:   mode_on = blink[0];
      default: mode_on = blink[1];
    endcase
    if (!reg_text && curcol_q && curv_q && mode_on) pix_bit = ~pix_bit;
    if (reg_rvs) pix_bit = ~pix_bit;

    if (hs_q || vs_q) begin
      rgbi_d = '0;
      de_d   = 1'b0;
    end else if (vis_q) begin
      rgbi_d = pix_bit ? fg_c : bg_c;
      de_d   = 1'b1;
    end else begin
      rgbi_d = reg_bg;
      de_d   = 1'b0;
    end
  end

  // Stage B: registered outputs, two enable ticks after the inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgbi    <= '0;
      de      <= 1'b0;
      hsync_o <= 1'b0;
      vsync_o <= 1'b0;
    end else if (enable) begin
      rgbi    <= rgbi_d;
      de      <= de_d;
      hsync_o <= hs_q;
      vsync_o <= vs_q;
    end
  end

endmodule
